// File: rtl/vga_pkg.sv
// Shared screen geometry, FSM state and rectangle command types for the VGA fill path.
package vga_pkg;

    localparam int NX       = 10;
    localparam int NY       = 9;
    localparam int COLOR_W  = 9;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic {
        IDLE = 1'b0,
        DRAW = 1'b1
    } rect_state_t;

    typedef struct packed {
        logic [NX-1:0]      x0;
        logic [NY-1:0]      y0;
        logic [NX-1:0]      w;
        logic [NY-1:0]      h;
        logic [COLOR_W-1:0] color;
    } rect_cmd_t;

endpackage

// File: rtl/raster_counter.sv
// Column/row sweep counter for a w x h rectangle; exposes next-state values so the
// caller can register coordinates in step with the counter. No backpressure.
module raster_counter #(
    parameter int NX_W = 10,
    parameter int NY_W = 9
) (
    input  logic            clock_i,
    input  logic            resetn_i,
    input  logic            load_i,
    input  logic            advance_i,
    input  logic [NX_W-1:0] w_i,
    input  logic [NY_W-1:0] h_i,
    output logic [NX_W-1:0] col_nxt_o,
    output logic [NY_W-1:0] row_nxt_o,
    output logic            last_o
);

    logic [NX_W-1:0] col_q, col_d, w_m1;
    logic [NY_W-1:0] row_q, row_d, h_m1;
    logic            col_end;

    assign w_m1    = w_i - NX_W'(1);
    assign h_m1    = h_i - NY_W'(1);
    assign col_end = (col_q == w_m1);
    assign last_o  = col_end && (row_q == h_m1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (load_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_q + NY_W'(1);
            end else begin
                col_d = col_q + NX_W'(1);
            end
        end
    end

    assign col_nxt_o = col_d;
    assign row_nxt_o = row_d;

    always_ff @(posedge clock_i) begin
        if (!resetn_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/vga_rect_fill.sv
// Rectangle fill engine: one pixel write per clock in raster order; VGA_RECT_FILL_CLIP_EN masks off-screen writes.
// First write 1 cycle after handshake, done at w*h+1; cmd_ready low for the whole sweep.
module vga_rect_fill #(
    parameter int nX      = vga_pkg::NX,
    parameter int nY      = vga_pkg::NY,
    parameter int COLOR_W = vga_pkg::COLOR_W
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [nX-1:0]      cmd_x0,
    input  logic [nY-1:0]      cmd_y0,
    input  logic [nX-1:0]      cmd_w,
    input  logic [nY-1:0]      cmd_h,
    input  logic [COLOR_W-1:0] cmd_color,
    output logic [nX-1:0]      x,
    output logic [nY-1:0]      y,
    output logic [COLOR_W-1:0] color,
    output logic               write,
    output logic               busy,
    output logic               done
);
    import vga_pkg::*;

`ifdef VGA_RECT_FILL_CLIP_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    rect_state_t        state_q, state_d;
    rect_cmd_t          cmd_q, cmd_d;
    logic [nX-1:0]      x_q, x_d, base_x, col_nxt;
    logic [nY-1:0]      y_q, y_d, base_y, row_nxt;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               write_q, write_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;
    logic               handshake, emit, cnt_load, cnt_adv, cnt_last, on_screen;
    logic [nX:0]        x_full;
    logic [nY:0]        y_full;

    assign handshake = cmd_valid && ready_q && (state_q == IDLE);

    raster_counter #(
        .NX_W (nX),
        .NY_W (nY)
    ) u_raster (
        .clock_i   (clock),
        .resetn_i  (resetn),
        .load_i    (cnt_load),
        .advance_i (cnt_adv),
        .w_i       (cmd_q.w),
        .h_i       (cmd_q.h),
        .col_nxt_o (col_nxt),
        .row_nxt_o (row_nxt),
        .last_o    (cnt_last)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;
        write_d  = 1'b0;
        done_d   = 1'b0;
        ready_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_adv  = 1'b0;
        emit     = 1'b0;
        base_x   = cmd_q.x0;
        base_y   = cmd_q.y0;

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (handshake) begin
                    cmd_d.x0    = cmd_x0;
                    cmd_d.y0    = cmd_y0;
                    cmd_d.w     = cmd_w;
                    cmd_d.h     = cmd_h;
                    cmd_d.color = cmd_color;
                    cnt_load    = 1'b1;
                    if ((cmd_w != '0) && (cmd_h != '0)) begin
                        // First pixel comes straight from the command inputs, not the latch.
                        state_d = DRAW;
                        ready_d = 1'b0;
                        emit    = 1'b1;
                        base_x  = cmd_x0;
                        base_y  = cmd_y0;
                        color_d = cmd_color;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    cnt_adv = 1'b1;
                    emit    = 1'b1;
                    color_d = cmd_q.color;
                end
            end
            default: state_d = IDLE;
        endcase

        x_full    = {1'b0, base_x} + {1'b0, col_nxt};
        y_full    = {1'b0, base_y} + {1'b0, row_nxt};
        on_screen = (x_full < (nX+1)'(SCREEN_W)) && (y_full < (nY+1)'(SCREEN_H));

        if (emit) begin
            x_d     = x_full[nX-1:0];
            y_d     = y_full[nY-1:0];
            write_d = !CLIP || on_screen;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            color_q <= '0;
            write_q <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            color_q <= color_d;
            write_q <= write_d;
            done_q  <= done_d;
            ready_q <= ready_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign color     = color_q;
    assign write     = write_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;
    assign busy      = (state_q == DRAW);

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: scoreboard of expected pixel writes and done pulses,
// each tagged with the cycle it must appear in.
module tb_vga_rect_fill;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [9:0] cmd_x0 = '0;
    logic [8:0] cmd_y0 = '0;
    logic [9:0] cmd_w = '0;
    logic [8:0] cmd_h = '0;
    logic [8:0] cmd_color = '0;
    logic       cmd_ready;
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] color;
    logic       write, busy, done;

    vga_rect_fill dut (
        .clock     (clock),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x0    (cmd_x0),
        .cmd_y0    (cmd_y0),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_color (cmd_color),
        .x         (x),
        .y         (y),
        .color     (color),
        .write     (write),
        .busy      (busy),
        .done      (done)
    );

    always #10 clock = ~clock;

    typedef struct {
        int x;
        int y;
        int c;
        int t;
    } pix_t;

    pix_t exp_q[$];
    int   exp_done[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   wr_cnt = 0;
    int   busy_cnt = 0;
    pix_t mp;
    int   md;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Monitor: every write / done pulse must match the head of its scoreboard queue.
    always @(negedge clock) begin
        if (busy === 1'b1) busy_cnt++;
        if (write === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                mp = exp_q.pop_front();
                chk("wr_x", 32'(x), 32'(mp.x));
                chk("wr_y", 32'(y), 32'(mp.y));
                chk("wr_color", 32'(color), 32'(mp.c));
                chk("wr_cycle", 32'(cyc), 32'(mp.t));
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                md = exp_done.pop_front();
                chk("done_cycle", 32'(cyc), 32'(md));
            end
        end
    end

    // Call at a negedge; returns at the negedge one cycle after the handshake.
    task automatic send(input int x0, input int y0, input int w, input int h, input int c,
                        output int hs);
        int   b;
        int   ax, ay;
        pix_t p;
        b = 0;
        cmd_valid = 1'b1;
        cmd_x0 = 10'(x0);
        cmd_y0 = 9'(y0);
        cmd_w = 10'(w);
        cmd_h = 9'(h);
        cmd_color = 9'(c);
        while (cmd_ready !== 1'b1 && b < 200) begin
            @(negedge clock);
            b++;
        end
        if (b >= 200) chk("ready_timeout", 32'd0, 32'd1);
        hs = cyc;
        if (w == 0 || h == 0) begin
            exp_done.push_back(hs + 1);
        end else begin
            for (int r = 0; r < h; r++) begin
                for (int col = 0; col < w; col++) begin
                    ax = x0 + col;
                    ay = y0 + r;
                    p.x = ax % 1024;
                    p.y = ay % 512;
                    p.c = c;
                    p.t = hs + 1 + r * w + col;
`ifdef VGA_RECT_FILL_CLIP_EN
                    if (ax < 640 && ay < 480) exp_q.push_back(p);
`else
                    exp_q.push_back(p);
`endif
                end
            end
            exp_done.push_back(hs + w * h + 1);
        end
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        cmd_x0 = 10'($urandom);
        cmd_y0 = 9'($urandom);
        cmd_w = 10'($urandom);
        cmd_h = 9'($urandom);
        cmd_color = 9'($urandom);
        @(negedge clock);
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((exp_q.size() != 0 || exp_done.size() != 0) && b < 2000) begin
            @(negedge clock);
            b++;
        end
        chk("drain", 32'(exp_q.size() + exp_done.size()), 32'd0);
        repeat (3) @(negedge clock);
    endtask

    task automatic run(input int x0, input int y0, input int w, input int h, input int c,
                       input int n_wr, input int n_busy);
        int wr0, bz0, hs;
        wr0 = wr_cnt;
        bz0 = busy_cnt;
        send(x0, y0, w, h, c, hs);
        wait_idle();
        chk("write_count", 32'(wr_cnt - wr0), 32'(n_wr));
        chk("busy_count", 32'(busy_cnt - bz0), 32'(n_busy));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_a, hs_b, wr0;

        repeat (3) @(negedge clock);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_color", 32'(color), 32'd0);
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 32'(cmd_ready), 32'd1);

        run(10, 20, 3, 2, 'h1FF, 6, 6);

        wr0 = wr_cnt;
        send(3, 4, 0, 5, 'h0AA, hs_a);
        chk("zero_ready", 32'(cmd_ready), 32'd1);
        chk("zero_busy", 32'(busy), 32'd0);
        wait_idle();
        chk("zero_writes", 32'(wr_cnt - wr0), 32'd0);

        wr0 = wr_cnt;
        send(0, 0, 1, 1, 'h007, hs_a);
        send(639, 479, 1, 1, 'h038, hs_b);
        chk("b2b_gap", 32'(hs_b - hs_a), 32'd2);
        wait_idle();
        chk("b2b_writes", 32'(wr_cnt - wr0), 32'd2);

`ifdef VGA_RECT_FILL_CLIP_EN
        run(638, 478, 4, 4, 'h0C3, 4, 16);
`else
        run(638, 478, 4, 4, 'h0C3, 16, 16);
`endif
        run(100, 50, 5, 3, 'h0AA, 15, 15);

        send(0, 0, 8, 8, 'h155, hs_a);
        repeat (9) @(negedge clock);
        @(posedge clock);
        #1;
        resetn = 1'b0;
        @(posedge clock);
        #1;
        resetn = 1'b1;
        @(negedge clock);
        chk("abort_write", 32'(write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        exp_done.delete();
        @(negedge clock);
        chk("abort_ready_back", 32'(cmd_ready), 32'd1);
        run(5, 5, 2, 2, 'h011, 4, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
